instr_sequencer: RTL

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer_pkg.sv | 32 +++
 rtl/instr_sequencer_watchdog.sv | 30 +++
 rtl/instr_sequencer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/instr_sequencer_pkg.sv
// Shared opcode, bus destination and FSM state encodings
// for the crypto instruction sequencer.
package instr_sequencer_pkg;

  localparam logic [1:0] OP_AES_ENC = 2'b00;
  localparam logic [1:0] OP_AES_DEC = 2'b01;
  localparam logic [1:0] OP_SHA     = 2'b10;
  localparam logic [1:0] OP_RSVD    = 2'b11;

  localparam logic [1:0] DEST_KEY = 2'b00;
  localparam logic [1:0] DEST_TXT = 2'b01;
  localparam logic [1:0] DEST_WB  = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_KEY_REQ  = 4'd1,
    S_KEY_WAIT = 4'd2,
    S_TXT_REQ  = 4'd3,
    S_TXT_WAIT = 4'd4,
    S_START    = 4'd5,
    S_RUN      = 4'd6,
    S_WB_REQ   = 4'd7,
    S_WB_WAIT  = 4'd8
  } state_e;

  // States guarded by the watchdog
  function automatic logic is_wait(input state_e s);
    return (s == S_KEY_WAIT) || (s == S_TXT_WAIT) ||
           (s == S_RUN)      || (s == S_WB_WAIT);
  endfunction

endpackage

// File: rtl/instr_sequencer_watchdog.sv
// Saturating watchdog counter for sequencer wait states.
// Ports: clk, rst, i_clear, i_enable -> o_expired.
module seq_watchdog #(
  parameter int W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [W-1:0] MAX  = '1;
  localparam logic [W-1:0] LAST = MAX - W'(1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != MAX)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  // Flags the cycle whose edge brings the count to all-ones
  assign o_expired = i_enable &&
                     ((r_cnt == LAST) || (r_cnt == MAX));

endmodule

// File: rtl/instr_sequencer.sv
// Sequences key/text fetch, core run and writeback per instruction.
// Ports: in_* handshake, bus_* commands, core_* control, busy, err_*.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int ADDRW   = 8,
  parameter int OPCODEW = 2,
  parameter int TMO_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OPCODEW-1:0] in_opcode,
  input  logic [ADDRW-1:0]   in_key_addr,
  input  logic [ADDRW-1:0]   in_text_addr,
  output logic               bus_valid,
  input  logic               bus_ready,
  output logic [ADDRW-1:0]   bus_addr,
  output logic [1:0]         bus_dest,
  input  logic               bus_done,
  output logic               core_start,
  output logic [OPCODEW-1:0] core_mode,
  input  logic               core_done,
  output logic               busy,
  output logic               err_opcode,
  output logic               err_timeout
);

  state_e             r_state;
  logic [OPCODEW-1:0] r_opcode;
  logic [ADDRW-1:0]   r_key;
  logic [ADDRW-1:0]   r_text;
  logic               r_err_op;
  logic               r_err_tmo;

  logic w_wait;
  logic w_expired;
  logic w_accept;

  assign w_wait   = is_wait(r_state);
  assign w_accept = in_valid && in_ready;

  // No wait state transitions straight into another,
  // so holding the count clear outside them clears it on entry
  seq_watchdog #(.W(TMO_W)) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (!w_wait),
    .i_enable  (w_wait),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_opcode  <= '0;
      r_key     <= '0;
      r_text    <= '0;
      r_err_op  <= 1'b0;
      r_err_tmo <= 1'b0;
    end else begin
      r_err_op  <= 1'b0;
      r_err_tmo <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_opcode <= in_opcode;
            r_key    <= in_key_addr;
            r_text   <= in_text_addr;
            unique case (in_opcode)
              OPCODEW'(OP_AES_ENC),
              OPCODEW'(OP_AES_DEC): r_state  <= S_KEY_REQ;
              OPCODEW'(OP_SHA):     r_state  <= S_TXT_REQ;
              default:              r_err_op <= 1'b1;
            endcase
          end
        end
        S_KEY_REQ: begin
          if (bus_ready) r_state <= S_KEY_WAIT;
        end
        S_KEY_WAIT: begin
          if (bus_done) begin
            r_state <= S_TXT_REQ;
          end else if (w_expired) begin
            r_state   <= S_IDLE;
            r_err_tmo <= 1'b1;
          end
        end
        S_TXT_REQ: begin
          if (bus_ready) r_state <= S_TXT_WAIT;
        end
        S_TXT_WAIT: begin
          if (bus_done) begin
            r_state <= S_START;
          end else if (w_expired) begin
            r_state   <= S_IDLE;
            r_err_tmo <= 1'b1;
          end
        end
        S_START: begin
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (core_done) begin
            r_state <= S_WB_REQ;
          end else if (w_expired) begin
            r_state   <= S_IDLE;
            r_err_tmo <= 1'b1;
          end
        end
        S_WB_REQ: begin
          if (bus_ready) r_state <= S_WB_WAIT;
        end
        S_WB_WAIT: begin
          if (bus_done) begin
            r_state <= S_IDLE;
          end else if (w_expired) begin
            r_state   <= S_IDLE;
            r_err_tmo <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus_valid = 1'b0;
    bus_addr  = '0;
    bus_dest  = DEST_KEY;
    unique case (r_state)
      S_KEY_REQ: begin
        bus_valid = 1'b1;
        bus_addr  = r_key;
        bus_dest  = DEST_KEY;
      end
      S_TXT_REQ: begin
        bus_valid = 1'b1;
        bus_addr  = r_text;
        bus_dest  = DEST_TXT;
      end
      S_WB_REQ: begin
        bus_valid = 1'b1;
        bus_addr  = r_text;
        bus_dest  = DEST_WB;
      end
      default: ;
    endcase
  end

  // Gated by rst so nothing is offered while reset is held
  assign in_ready    = (r_state == S_IDLE) && !rst;
  assign busy        = (r_state != S_IDLE);
  assign core_start  = (r_state == S_START);
  assign core_mode   = r_opcode;
  assign err_opcode  = r_err_op;
  assign err_timeout = r_err_tmo;

endmodule
